// File: rtl/rsa_exp_ctrl_if.sv
// Bundles the host request/result signals with the modulo-product and Montgomery unit handshakes.
// master = exponentiation controller; slave = host and arithmetic units.
interface rsa_exp_ctrl_if #(
    parameter int BITS = 256
);
    logic            i_start;
    logic [BITS-1:0] i_a;
    logic [BITS-1:0] i_d;
    logic [BITS-1:0] i_n;
    logic [BITS-1:0] o_a_pow_d;
    logic            o_finished;
    logic            o_busy;
    logic            mp_rst_n;
    logic [BITS-1:0] mp_y;
    logic [BITS-1:0] mp_n;
    logic [BITS-1:0] mp_m;
    logic            mp_finish;
    logic            mt_start;
    logic [BITS-1:0] mt_a;
    logic [BITS-1:0] mt_b;
    logic [BITS-1:0] mt_n;
    logic [BITS-1:0] mt_m;
    logic            mt_finish;

    modport master (
        input  i_start, i_a, i_d, i_n, mp_m, mp_finish, mt_m, mt_finish,
        output o_a_pow_d, o_finished, o_busy, mp_rst_n, mp_y, mp_n,
               mt_start, mt_a, mt_b, mt_n
    );

    modport slave (
        output i_start, i_a, i_d, i_n, mp_m, mp_finish, mt_m, mt_finish,
        input  o_a_pow_d, o_finished, o_busy, mp_rst_n, mp_y, mp_n,
               mt_start, mt_a, mt_b, mt_n
    );
endinterface

// File: rtl/rsa_exp_ctrl.sv
// LSB-first square-and-multiply sequencer for a^d mod N, time-sharing one Montgomery
// multiplier between the multiply and square steps after a single Montgomery-domain transform.
module rsa_exp_ctrl #(
    parameter int BITS  = 256,
    parameter int CNT_W = 9
) (
    input  logic           clk,
    input  logic           rst,
    rsa_exp_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREP_CLR = 3'd1,
        S_PREP     = 3'd2,
        S_MUL      = 3'd3,
        S_SQR      = 3'd4,
        S_OUT      = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [BITS-1:0] a_q, a_d, d_q, d_d, n_q, n_d;
    logic [BITS-1:0] m_q, m_d, t_q, t_d, res_q, res_d;
    logic [BITS-1:0] mt_a_q, mt_a_d, mt_b_q, mt_b_d;
    logic            fin_q, fin_d, busy_q, busy_d;
    logic            mp_rst_n_q, mp_rst_n_d, mt_start_q, mt_start_d;
    logic            mt_done_s, last_bit_s, issue_s;

    // A finish coinciding with our own request pulse belongs to no request of ours.
    assign mt_done_s  = bus.mt_finish & ~mt_start_q;
    assign last_bit_s = (idx_q == CNT_W'(BITS - 1));
    assign issue_s    = ((state_d == S_MUL) || (state_d == S_SQR)) &&
                        ((state_d != state_q) || mt_done_s);

    assign bus.o_a_pow_d  = res_q;
    assign bus.o_finished = fin_q;
    assign bus.o_busy     = busy_q;
    assign bus.mp_rst_n   = mp_rst_n_q;
    assign bus.mp_y       = a_q;
    assign bus.mp_n       = n_q;
    assign bus.mt_start   = mt_start_q;
    assign bus.mt_a       = mt_a_q;
    assign bus.mt_b       = mt_b_q;
    assign bus.mt_n       = n_q;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decision; d_q[0] is always the exponent bit being processed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_start) state_d = S_PREP_CLR;
                else             state_d = S_IDLE;
            end
            S_PREP_CLR: state_d = S_PREP;
            S_PREP: begin
                if (bus.mp_finish) state_d = d_q[0] ? S_MUL : S_SQR;
                else               state_d = S_PREP;
            end
            S_MUL: begin
                if (mt_done_s) state_d = S_SQR;
                else           state_d = S_MUL;
            end
            S_SQR: begin
                if (!mt_done_s)     state_d = S_SQR;
                else if (last_bit_s) state_d = S_OUT;
                else                 state_d = d_q[1] ? S_MUL : S_SQR;
            end
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        a_d        = a_q;
        d_d        = d_q;
        n_d        = n_q;
        m_d        = m_q;
        t_d        = t_q;
        idx_d      = idx_q;
        mt_a_d     = mt_a_q;
        mt_b_d     = mt_b_q;
        res_d      = res_q;
        fin_d      = 1'b0;
        mt_start_d = 1'b0;
        busy_d     = (state_d != S_IDLE);
        mp_rst_n_d = (state_d == S_PREP);
        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    a_d   = bus.i_a;
                    d_d   = bus.i_d;
                    n_d   = bus.i_n;
                    m_d   = BITS'(1);
                    idx_d = {CNT_W{1'b0}};
                end else begin
                    idx_d = idx_q;
                end
            end
            S_PREP: begin
                if (bus.mp_finish) t_d = bus.mp_m;
                else               t_d = t_q;
            end
            S_MUL: begin
                if (mt_done_s) m_d = bus.mt_m;
                else           m_d = m_q;
            end
            S_SQR: begin
                if (mt_done_s) begin
                    t_d = bus.mt_m;
                    d_d = d_q >> 1;
                    if (last_bit_s) idx_d = idx_q;
                    else            idx_d = idx_q + CNT_W'(1);
                end else begin
                    t_d = t_q;
                end
            end
            default: res_d = res_q;
        endcase
        // Operands use the freshly latched m/t so the new request sees this cycle's result.
        if (issue_s) begin
            mt_start_d = 1'b1;
            mt_a_d     = (state_d == S_MUL) ? m_d : t_d;
            mt_b_d     = t_d;
        end else begin
            mt_start_d = 1'b0;
        end
        if (state_d == S_OUT) begin
            res_d = m_q;
            fin_d = 1'b1;
        end else begin
            fin_d = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q        <= {BITS{1'b0}};
            d_q        <= {BITS{1'b0}};
            n_q        <= {BITS{1'b0}};
            m_q        <= {BITS{1'b0}};
            t_q        <= {BITS{1'b0}};
            idx_q      <= {CNT_W{1'b0}};
            mt_a_q     <= {BITS{1'b0}};
            mt_b_q     <= {BITS{1'b0}};
            res_q      <= {BITS{1'b0}};
            fin_q      <= 1'b0;
            busy_q     <= 1'b0;
            mp_rst_n_q <= 1'b0;
            mt_start_q <= 1'b0;
        end else begin
            a_q        <= a_d;
            d_q        <= d_d;
            n_q        <= n_d;
            m_q        <= m_d;
            t_q        <= t_d;
            idx_q      <= idx_d;
            mt_a_q     <= mt_a_d;
            mt_b_q     <= mt_b_d;
            res_q      <= res_d;
            fin_q      <= fin_d;
            busy_q     <= busy_d;
            mp_rst_n_q <= mp_rst_n_d;
            mt_start_q <= mt_start_d;
        end
    end
endmodule

// File: tb/tb_rsa_exp_ctrl.sv
// Scoreboard bench: an 8-bit and a 256-bit controller, each with behavioural modulo-product
// (4-cycle) and Montgomery (3-cycle) units; expected operands and results queued at stimulus time.
module tb_rsa_exp_ctrl;
    typedef struct packed {
        logic [255:0] a;
        logic [255:0] b;
    } op_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   fin8 = 0;
    int   fin256 = 0;
    logic spur_mt8 = 1'b0;
    logic spur_mp8 = 1'b0;
    logic sel_big = 1'b0;
    logic s_fin, s_busy, s_mprst;

    op_t          q_op8[$];
    op_t          q_op256[$];
    logic [255:0] q_res8[$];
    logic [255:0] q_res256[$];

    rsa_exp_ctrl_if #(.BITS(8))   bus8();
    rsa_exp_ctrl_if #(.BITS(256)) bus256();

    rsa_exp_ctrl #(.BITS(8), .CNT_W(4)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
    rsa_exp_ctrl #(.BITS(256), .CNT_W(9)) u_dut256 (.clk(clk), .rst(rst), .bus(bus256));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign s_fin   = sel_big ? bus256.o_finished : bus8.o_finished;
    assign s_busy  = sel_big ? bus256.o_busy     : bus8.o_busy;
    assign s_mprst = sel_big ? bus256.mp_rst_n   : bus8.mp_rst_n;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // x*y*2^-bits mod n, bit-serial
    function automatic logic [255:0] mont(input logic [255:0] x, input logic [255:0] y,
                                          input logic [255:0] n, input int bits);
        logic [259:0] s;
        s = 260'd0;
        for (int i = 0; i < bits; i++) begin
            if (x[i]) s = s + {4'd0, y};
            if (s[0]) s = s + {4'd0, n};
            s = s >> 1;
        end
        if (s >= {4'd0, n}) s = s - {4'd0, n};
        return s[255:0];
    endfunction

    function automatic logic [255:0] mp_calc(input logic [255:0] y, input logic [255:0] n, input int bits);
        logic [511:0] p;
        p = {256'd0, y} << bits;
        p = p % {256'd0, n};
        return p[255:0];
    endfunction

    function automatic logic [255:0] modexp(input logic [255:0] a, input logic [255:0] d,
                                            input logic [255:0] n, input int bits);
        logic [511:0] r, b, nn;
        nn = {256'd0, n};
        r  = 512'd1;
        b  = {256'd0, a} % nn;
        for (int i = 0; i < bits; i++) begin
            if (d[i]) r = (r * b) % nn;
            b = (b * b) % nn;
        end
        return r[255:0];
    endfunction

    // Behavioural units for the 8-bit controller
    logic [1:0] mp8_cnt;
    logic       mt8_pipe, mt8_fin;
    logic [7:0] mt8_res;
    always @(posedge clk) begin
        if (!bus8.mp_rst_n) mp8_cnt <= 2'd0;
        else if (mp8_cnt != 2'd3) mp8_cnt <= mp8_cnt + 2'd1;
    end
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mt8_pipe <= 1'b0;
            mt8_fin  <= 1'b0;
            mt8_res  <= 8'd0;
        end else begin
            mt8_pipe <= bus8.mt_start;
            mt8_fin  <= mt8_pipe;
            if (bus8.mt_start)
                mt8_res <= 8'(mont({248'd0, bus8.mt_a}, {248'd0, bus8.mt_b}, {248'd0, bus8.mt_n}, 8));
        end
    end
    assign bus8.mp_finish = (mp8_cnt == 2'd3) | spur_mp8;
    assign bus8.mp_m      = 8'(mp_calc({248'd0, bus8.mp_y}, {248'd0, bus8.mp_n}, 8));
    assign bus8.mt_finish = mt8_fin | spur_mt8;
    assign bus8.mt_m      = mt8_res;

    // Behavioural units for the 256-bit controller
    logic [1:0]   mp256_cnt;
    logic         mt256_pipe, mt256_fin;
    logic [255:0] mt256_res;
    always @(posedge clk) begin
        if (!bus256.mp_rst_n) mp256_cnt <= 2'd0;
        else if (mp256_cnt != 2'd3) mp256_cnt <= mp256_cnt + 2'd1;
    end
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mt256_pipe <= 1'b0;
            mt256_fin  <= 1'b0;
            mt256_res  <= 256'd0;
        end else begin
            mt256_pipe <= bus256.mt_start;
            mt256_fin  <= mt256_pipe;
            if (bus256.mt_start) mt256_res <= mont(bus256.mt_a, bus256.mt_b, bus256.mt_n, 256);
        end
    end
    assign bus256.mp_finish = (mp256_cnt == 2'd3);
    assign bus256.mp_m      = mp_calc(bus256.mp_y, bus256.mp_n, 256);
    assign bus256.mt_finish = mt256_fin;
    assign bus256.mt_m      = mt256_res;

    // Scoreboard: every Montgomery request and every result is matched against the queues
    always @(negedge clk) begin
        if (rst) begin
            if (bus8.mt_start) begin
                if (q_op8.size() == 0) begin
                    check_val("op8_extra", 256'(q_op8.size()), 256'd1);
                end else begin
                    op_t op;
                    op = q_op8.pop_front();
                    check_val("mt_a8", {248'd0, bus8.mt_a}, op.a);
                    check_val("mt_b8", {248'd0, bus8.mt_b}, op.b);
                end
            end
            if (bus8.o_finished) begin
                fin8++;
                if (q_res8.size() == 0) check_val("res8_extra", 256'(q_res8.size()), 256'd1);
                else check_val("res8", {248'd0, bus8.o_a_pow_d}, q_res8.pop_front());
            end
            if (bus256.mt_start) begin
                if (q_op256.size() == 0) begin
                    check_val("op256_extra", 256'(q_op256.size()), 256'd1);
                end else begin
                    op_t op;
                    op = q_op256.pop_front();
                    check_val("mt_a256", bus256.mt_a, op.a);
                    check_val("mt_b256", bus256.mt_b, op.b);
                end
            end
            if (bus256.o_finished) begin
                fin256++;
                if (q_res256.size() == 0) check_val("res256_extra", 256'(q_res256.size()), 256'd1);
                else check_val("res256", bus256.o_a_pow_d, q_res256.pop_front());
            end
        end
    end

    task automatic push_exp(input bit big, input logic [255:0] a, input logic [255:0] d,
                            input logic [255:0] n, input int bits);
        op_t          op;
        logic [255:0] m, t;
        t = mp_calc(a, n, bits);
        m = 256'd1;
        for (int i = 0; i < bits; i++) begin
            if (d[i]) begin
                op.a = m;
                op.b = t;
                if (big) q_op256.push_back(op); else q_op8.push_back(op);
                m = mont(m, t, n, bits);
            end
            op.a = t;
            op.b = t;
            if (big) q_op256.push_back(op); else q_op8.push_back(op);
            t = mont(t, t, n, bits);
        end
        if (big) q_res256.push_back(modexp(a, d, n, bits));
        else     q_res8.push_back(modexp(a, d, n, bits));
    endtask

    task automatic run_op(input bit big, input logic [255:0] a, input logic [255:0] d,
                          input logic [255:0] n, input bit disturb);
        int           bits, waited, start_cyc;
        logic [255:0] dm;
        bits    = big ? 256 : 8;
        dm      = big ? d : (d & 256'hFF);
        sel_big = big;
        @(negedge clk);
        if (big) begin
            bus256.i_a = a; bus256.i_d = d; bus256.i_n = n; bus256.i_start = 1'b1;
        end else begin
            bus8.i_a = a[7:0]; bus8.i_d = d[7:0]; bus8.i_n = n[7:0]; bus8.i_start = 1'b1;
        end
        push_exp(big, a, dm, n, bits);
        start_cyc = cyc;
        @(negedge clk);
        bus8.i_start   = 1'b0;
        bus256.i_start = 1'b0;
        check_val("busy_on", 256'(s_busy), 256'd1);
        check_val("mp_clr", 256'(s_mprst), 256'd0);
        @(negedge clk);
        check_val("mp_rel", 256'(s_mprst), 256'd1);
        waited = 0;
        while (!s_fin && waited < 5000) begin
            if (disturb && waited == 8) begin
                bus8.i_start = 1'b1; bus8.i_a = 8'd9; bus8.i_d = 8'hFF; bus8.i_n = 8'd77;
            end else begin
                bus8.i_start = 1'b0;
            end
            @(negedge clk);
            waited++;
        end
        bus8.i_start = 1'b0;
        check_val("done_seen", 256'(s_fin), 256'd1);
        check_val("latency", 256'(cyc - start_cyc + 1), 256'(2 + 4 + (bits + $countones(dm)) * 3 + 1));
        check_val("busy_fin", 256'(s_busy), 256'd1);
        @(negedge clk);
        check_val("fin_pulse", 256'(s_fin), 256'd0);
        check_val("busy_off", 256'(s_busy), 256'd0);
    endtask

    initial begin
        logic [255:0] p256;
        p256 = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
        bus8.i_start = 1'b0;   bus8.i_a = 8'd0;     bus8.i_d = 8'd0;     bus8.i_n = 8'd0;
        bus256.i_start = 1'b0; bus256.i_a = 256'd0; bus256.i_d = 256'd0; bus256.i_n = 256'd0;
        repeat (3) @(negedge clk);
        check_val("rst_res", {248'd0, bus8.o_a_pow_d}, 256'd0);
        check_val("rst_fin", 256'(bus8.o_finished), 256'd0);
        check_val("rst_busy", 256'(bus8.o_busy), 256'd0);
        check_val("rst_mprst", 256'(bus8.mp_rst_n), 256'd0);
        check_val("rst_mtst", 256'(bus8.mt_start), 256'd0);
        check_val("rst_busy256", 256'(bus256.o_busy), 256'd0);
        rst = 1'b1;

        // Spurious unit handshakes while idle
        @(negedge clk);
        spur_mt8 = 1'b1;
        spur_mp8 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            spur_mt8 = 1'b0;
            check_val("spur_busy", 256'(bus8.o_busy), 256'd0);
            check_val("spur_mtst", 256'(bus8.mt_start), 256'd0);
            check_val("spur_mprst", 256'(bus8.mp_rst_n), 256'd0);
            check_val("spur_fin", 256'(bus8.o_finished), 256'd0);
        end
        spur_mp8 = 1'b0;

        run_op(1'b0, 256'd7, 256'd3, 256'd143, 1'b0);
        run_op(1'b0, 256'd5, 256'd0, 256'd143, 1'b0);
        run_op(1'b0, 256'd7, 256'd3, 256'd143, 1'b1);

        // Abort during the first multiply wait
        sel_big = 1'b0;
        @(negedge clk);
        bus8.i_a = 8'd7; bus8.i_d = 8'd3; bus8.i_n = 8'd143; bus8.i_start = 1'b1;
        push_exp(1'b0, 256'd7, 256'd3, 256'd143, 8);
        @(negedge clk);
        bus8.i_start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("abort_res", {248'd0, bus8.o_a_pow_d}, 256'd0);
        check_val("abort_busy", 256'(bus8.o_busy), 256'd0);
        check_val("abort_fin", 256'(bus8.o_finished), 256'd0);
        check_val("abort_mprst", 256'(bus8.mp_rst_n), 256'd0);
        check_val("abort_mtst", 256'(bus8.mt_start), 256'd0);
        q_op8.delete();
        q_res8.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_op(1'b0, 256'd3, 256'd5, 256'd143, 1'b0);

        run_op(1'b1, 256'd2, {256{1'b1}}, p256, 1'b0);

        repeat (10) @(negedge clk);
        check_val("ops8_left", 256'(q_op8.size()), 256'd0);
        check_val("ops256_left", 256'(q_op256.size()), 256'd0);
        check_val("res8_left", 256'(q_res8.size()), 256'd0);
        check_val("fin8_count", 256'(fin8), 256'd4);
        check_val("fin256_count", 256'(fin256), 256'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rsa_exp_ctrl.md
Name: rsa_exp_ctrl

Overview:
- Sequencer for modular exponentiation o_a_pow_d = i_a^i_d mod i_n, using LSB-first square-and-multiply.
- Drives one modulo-product unit for the Montgomery-domain transform t = a*2^BITS mod N.
- Drives one shared Montgomery multiplier, which computes x*y*2^-BITS mod N. The controller time-shares it between the multiply step and the square step.
- Sits between the top-level I/O wrapper and the two arithmetic units, and owns their start/reset handshakes.

Parameters:
- BITS, 256, operand, modulus and exponent width; number of exponent bits processed.
- CNT_W, 9, bit-index counter width; must satisfy 2^CNT_W > BITS.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle request; accepted only in IDLE
- i_a  in  BITS  base; latched on accept
- i_d  in  BITS  exponent; latched on accept
- i_n  in  BITS  modulus; latched on accept
- o_a_pow_d  out  BITS  result; valid when o_finished=1, held until next accept
- o_finished  out  1  one-cycle done pulse
- o_busy  out  1  high from accept until o_finished inclusive
- mp_rst_n  out  1  active-low local reset to modulo-product unit
- mp_y  out  BITS  latched base to modulo-product unit
- mp_n  out  BITS  latched modulus to modulo-product unit
- mp_m  in  BITS  modulo-product result
- mp_finish  in  1  level; high while mp_m is valid
- mt_start  out  1  one-cycle Montgomery request pulse
- mt_a  out  BITS  Montgomery operand x
- mt_b  out  BITS  Montgomery operand y
- mt_n  out  BITS  latched modulus to Montgomery unit
- mt_m  in  BITS  Montgomery result
- mt_finish  in  1  one-cycle Montgomery done pulse

Behaviour:
- Reset values: o_a_pow_d=0, o_finished=0, o_busy=0, mp_rst_n=0, mt_start=0, state=IDLE, idx=0, internal m=0 and t=0.
- Reset mid-operation aborts the operation immediately. No result and no o_finished pulse are produced.
- mp_rst_n is 0 in every state except PREP. The modulo-product unit is therefore always freshly cleared before use.
- States:
  - IDLE: on i_start, latch a/d/n, set m=1, idx=0, o_busy=1, go to PREP_CLR. i_start while not in IDLE is ignored.
  - PREP_CLR: one cycle with mp_rst_n=0, then go to PREP.
  - PREP: mp_rst_n=1. On the first cycle with mp_finish=1, latch t=mp_m, then go to MUL if d[0]=1, else go to SQR.
  - MUL: on the entry cycle, pulse mt_start with mt_a=m, mt_b=t. On mt_finish, latch m=mt_m and go to SQR.
  - SQR: on the entry cycle, pulse mt_start with mt_a=t, mt_b=t. On mt_finish, latch t=mt_m.
    - If idx==BITS-1, go to OUT.
    - Else idx=idx+1 and go to MUL if d[idx+1]=1, else go to SQR (re-enter, new pulse).
  - OUT: o_a_pow_d=m, o_finished=1 for exactly this cycle, o_busy=1. Next cycle go to IDLE with o_busy=0.
- mt_start is a single-cycle pulse per request. A new pulse is issued each time MUL or SQR is entered, including SQR to SQR.
- mt_a and mt_b are held stable from the pulse until mt_finish.
- mt_finish and mp_finish are ignored outside their waiting states. A mt_finish in the same cycle as mt_start is not accepted.
- Request counts per operation: exactly 1 PREP, popcount(d) MUL requests, BITS SQR requests.
- Result is raw m. m starts at 1, so the Montgomery factors cancel.
- Modulus handling: N=0 or N even gives undefined o_a_pow_d, but the FSM still terminates.
- Latency with ideal units (PREP done after P cycles, Montgomery done K cycles after pulse): 1 + 1 + P + (BITS+popcount(d))*K + 1 cycles from accept to o_finished.
- Inputs changed after accept have no effect on the running operation.

Test Plan:
- Use behavioral models in the bench: mp gives (y<<BITS)%N after 4 cycles; mt gives (x*y*2^-BITS)%N after 3 cycles.
- BITS=8, a=7, d=3, N=143 -> o_a_pow_d=57; 2 MUL, 8 SQR requests; o_finished one cycle; o_busy low next cycle.
- BITS=8, a=5, d=0, N=143 -> o_a_pow_d=1; 0 MUL, 8 SQR; mp_rst_n low exactly 1 cycle before PREP.
- BITS=256, d=all ones, a=2, N=odd 256-bit prime -> result matches golden model; accept-to-finish latency = 2+4+512*3+1 cycles.
- Busy rejection: i_start pulsed, and i_a/i_d changed, during SQR -> ignored; result unchanged; exactly one o_finished.
- Reset mid-operation: rst low during MUL wait -> all outputs at reset values, mp_rst_n=0; a new start then completes correctly.
- Spurious handshakes: mt_finish pulsed in IDLE and mp_finish high in IDLE -> no state change, no outputs asserted.
